lfsr_prng: RTL and testbench
============================

# lfsr_prng

Parametrised Fibonacci LFSR pseudo-random word generator: the successor to the team's fixed 32-bit LFSR RNG. Width, feedback polynomial, seed and decorrelation step count are generic. Words leave through a valid/ready stream. The block supports run-time reseeding and automatic recovery from the all-zero lock-up state. It sits between test-pattern, dither and scrambler consumers and any seed source, such as a CSR or TRNG.

## Interface
- WIDTH, 32: LFSR and output width, 4..64.
- TAPS, 32'h8020_0003: feedback mask. Bit i set means stage i+1 is tapped. The default is taps 32, 22, 2, 1.
- SEED, 32'hDEAD_BEEF: reset and substitute seed. It is WIDTH bits and must be non-zero.
- STEPS, 1: number of LFSR shifts between consecutive output words, 1..WIDTH.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  single-cycle request to load seed_data.
- seed_data  in  WIDTH  new seed value.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  current LFSR state, registered.
- busy  out  1  high while stepping (FILL state).
- zero_seed  out  1  one-cycle pulse: a zero seed was replaced by SEED.
- lockup  out  1  one-cycle pulse: a zero next-state was replaced by SEED.

## Operation
- One clock; reset is synchronous and active-high.
- Next-state function: fb = ^(lfsr & TAPS); nxt = {lfsr[WIDTH-2:0], fb}.
- Lock-up guard: if nxt == 0, load SEED instead and pulse lockup.
- States are HOLD and FILL. A step counter cnt counts 0..STEPS-1, with width clog2(STEPS)+1.
- HOLD:
  - out_valid=1.
  - When out_valid && out_ready (handshake), the LFSR performs one shift.
  - If STEPS==1, stay in HOLD.
  - Otherwise go to FILL with cnt=1.
- FILL:
  - out_valid=0, busy=1.
  - Shift once per cycle and increment cnt.
  - When cnt==STEPS-1, perform that shift and go to HOLD.
- Consecutive accepted words are therefore separated by exactly STEPS shifts.
- out_data is the LFSR register. It is stable while in HOLD without a handshake.
- seed_load has the highest priority below rst, in any state:
  - lfsr <= (seed_data==0 ? SEED : seed_data).
  - State goes to HOLD, cnt goes to 0.
  - zero_seed pulses next cycle iff seed_data==0.
  - Any shift or lock-up substitution for that cycle is discarded.
- seed_load coincident with a handshake: the current word counts as consumed, and the next word is the new seed.
- seed_load coincident with rst: rst wins.
- A seeded word is presented before any shift, so the seed itself is the first word output.

## Timing
- Reset values:
  - lfsr=SEED, state=HOLD, cnt=0.
  - out_valid=1, out_data=SEED.
  - busy=0, zero_seed=0, lockup=0.
- First word is valid the cycle after rst deasserts.
- Throughput: one word per STEPS cycles under continuous out_ready. With STEPS=1, one word per cycle.
- Seed-to-output latency: 1 cycle from the seed_load edge to out_valid=1 with the seed on out_data.
- rst asserted mid-FILL: the next cycle shows reset values. No partially stepped word is ever presented.
- out_ready is ignored outside HOLD.
- zero_seed and lockup are registered. Each is high for exactly one cycle per event.
- lockup can coincide with a handshake or a FILL shift. That word or step then becomes SEED.

## Test plan
- Defaults, rst then out_ready=1 constantly -> out_data sequence 0xDEADBEEF, 0xBD5B7DDE, 0x7AB6FBBC on three consecutive cycles, with out_valid=1 throughout.
- Defaults, out_ready=0 for 10 cycles after reset -> out_data held at 0xDEADBEEF and out_valid=1 for all 10 cycles; asserting out_ready then gives 0xBD5B7DDE on the next cycle.
- STEPS=4, out_ready=1 -> word 0 = SEED, then busy=1 for 3 cycles, then word 1 = SEED advanced by 4 shifts (checked against a reference model); 16 words checked.
- seed_load=1 with seed_data=0x1234_5678, during FILL -> next cycle out_valid=1 and out_data=0x12345678. Repeat with seed_data=0 -> out_data=0xDEADBEEF and zero_seed high for one cycle.
- WIDTH=4, TAPS=4'b0100, SEED=4'h8, out_ready=1 -> words 0x8, 0x8, 0x8, … with lockup pulsing on each handshake, and out_data never 0.
- rst asserted on the 2nd FILL cycle with STEPS=8 -> next cycle out_data=SEED, out_valid=1, busy=0; rst asserted together with seed_load -> out_data=SEED.

Source files
------------

// File: rtl/lfsr_prng_if.sv
// Stream and seed-control bundle for lfsr_prng. The master side is the generator; the slave side
// is the consumer and seed source.
interface lfsr_prng_if #(
    parameter int unsigned WIDTH = 32
);
    logic             seed_load;
    logic [WIDTH-1:0] seed_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             zero_seed;
    logic             lockup;

    modport master (
        input  seed_load,
        input  seed_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output busy,
        output zero_seed,
        output lockup
    );

    modport slave (
        output seed_load,
        output seed_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  busy,
        input  zero_seed,
        input  lockup
    );
endinterface

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR word generator with a valid/ready output, STEPS shifts between words,
// run-time reseeding and substitution of SEED for any all-zero state.
module lfsr_prng #(
    parameter int unsigned     WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(32'hDEAD_BEEF),
    parameter int unsigned     STEPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    lfsr_prng_if.master     bus
);
    localparam int unsigned CW = $clog2(STEPS) + 1;

    typedef enum logic {StHold, StFill} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] lfsr_q;
    logic             valid_q;
    logic             busy_q;
    logic             zero_seed_q;
    logic             lockup_q;

    logic             fb;
    logic [WIDTH-1:0] nxt_raw;
    logic             nxt_zero;
    logic [WIDTH-1:0] nxt;

    always_comb begin
        fb       = ^(lfsr_q & TAPS);
        nxt_raw  = {lfsr_q[WIDTH-2:0], fb};
        nxt_zero = (nxt_raw == '0);
        nxt      = nxt_zero ? SEED : nxt_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            lfsr_q      <= SEED;
            valid_q     <= 1'b1;
            busy_q      <= 1'b0;
            zero_seed_q <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            zero_seed_q <= 1'b0;
            lockup_q    <= 1'b0;
            if (bus.seed_load) begin
                // Reseed overrides any shift or lock-up substitution in this cycle.
                lfsr_q      <= (bus.seed_data == '0) ? SEED : bus.seed_data;
                zero_seed_q <= (bus.seed_data == '0);
                state_q     <= StHold;
                cnt_q       <= '0;
                valid_q     <= 1'b1;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StHold: begin
                        if (bus.out_ready) begin
                            lfsr_q   <= nxt;
                            lockup_q <= nxt_zero;
                            if (STEPS > 1) begin
                                state_q <= StFill;
                                cnt_q   <= CW'(1);
                                valid_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    StFill: begin
                        lfsr_q   <= nxt;
                        lockup_q <= nxt_zero;
                        if (cnt_q == CW'(STEPS - 1)) begin
                            state_q <= StHold;
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= StHold;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out_data  = lfsr_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.zero_seed = zero_seed_q;
    assign bus.lockup    = lockup_q;
endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: directed checks on default and 4-bit lock-up builds, plus a randomized
// STEPS=4 build checked by a word scoreboard fed from a behavioural sequence model.
module tb_lfsr_prng;
    localparam logic [31:0] SEED_A  = 32'hDEAD_BEEF;
    localparam logic [31:0] TAPS_A  = 32'h8020_0003;
    localparam int          STEPS_A = 4;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_q[$];
    bit          gap_check = 1'b0;
    int          prev_hs   = -1;
    logic [31:0] cur;

    lfsr_prng_if #(.WIDTH(32)) ia ();
    lfsr_prng_if #(.WIDTH(32)) ib ();
    lfsr_prng_if #(.WIDTH(4))  ic ();

    lfsr_prng #(.WIDTH(32), .TAPS(TAPS_A), .SEED(SEED_A), .STEPS(STEPS_A)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ia)
    );
    lfsr_prng #(.WIDTH(32), .TAPS(TAPS_A), .SEED(SEED_A), .STEPS(1)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ib)
    );
    lfsr_prng #(.WIDTH(4), .TAPS(4'b0100), .SEED(4'h8), .STEPS(1)) dut_c (
        .clk(clk), .rst(rst_c), .bus(ic)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sequence model: each step shifts in the parity of the tapped bits; zero becomes SEED.
    function automatic logic [31:0] adv(input logic [31:0] s, input int n);
        logic [31:0] t = s;
        for (int i = 0; i < n; i++) begin
            t = (t << 1) | 32'($countones(t & TAPS_A) & 1);
            if (t == 32'd0) t = SEED_A;
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for dut_a.
    always @(negedge clk) begin
        chk("a_busy_vs_valid", ia.busy, !ia.out_valid);
        if (!rst_a && ia.out_valid && ia.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_extra_word: got %0h expected no word (cycle %0d)", ia.out_data, cyc);
            end else begin
                chk("a_word", ia.out_data, exp_q.pop_front());
            end
            if (gap_check && prev_hs >= 0) chk("a_gap", cyc - prev_hs, STEPS_A);
            prev_hs = cyc;
        end
        if (rst_a || ia.seed_load) prev_hs = -1;
    end

    task automatic run_words(input int n, input int pct);
        logic [31:0] w = cur;
        int remaining;
        int cycles = 0;
        logic hs;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(w);
            w = adv(w, STEPS_A);
        end
        remaining = n;
        tick();
        while (remaining > 0 && cycles < 1000) begin
            ia.out_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            hs = ia.out_valid && ia.out_ready;
            tick();
            if (hs) remaining--;
            cycles++;
        end
        ia.out_ready = 1'b0;
        chk("a_words_done", remaining, 0);
        cur = w;
    endtask

    // mode 0: reseed while idle; 1: reseed with a coincident handshake; 2: reseed mid-FILL.
    task automatic seed_end(input int mode, input logic [31:0] d);
        logic [31:0] e = (d == 32'd0) ? SEED_A : d;
        tick();
        ia.out_ready = 1'b0;
        repeat (5) tick();
        case (mode)
            0: begin
                ia.seed_load = 1'b1; ia.seed_data = d; tick();
            end
            1: begin
                exp_q.push_back(cur);
                ia.out_ready = 1'b1; ia.seed_load = 1'b1; ia.seed_data = d; tick();
            end
            default: begin
                exp_q.push_back(cur);
                ia.out_ready = 1'b1; tick();
                ia.out_ready = 1'b0; tick();
                ia.out_ready = 1'b1; ia.seed_load = 1'b1; ia.seed_data = d; tick();
            end
        endcase
        ia.seed_load = 1'b0;
        ia.out_ready = 1'b0;
        @(negedge clk);
        chk("a_seed_valid", ia.out_valid, 1'b1);
        chk("a_seed_word", ia.out_data, e);
        chk("a_zero_seed", ia.zero_seed, d == 32'd0);
        @(negedge clk);
        chk("a_zero_seed_clear", ia.zero_seed, 1'b0);
        chk("a_seed_hold", ia.out_data, e);
        cur = e;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp3 [3];
        logic [31:0] d;
        exp3 = '{32'hDEAD_BEEF, 32'hBD5B_7DDE, 32'h7AB6_FBBC};
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ia.seed_load = 1'b0; ia.seed_data = '0; ia.out_ready = 1'b0;
        ib.seed_load = 1'b0; ib.seed_data = '0; ib.out_ready = 1'b0;
        ic.seed_load = 1'b0; ic.seed_data = '0; ic.out_ready = 1'b0;
        repeat (2) tick();

        // Default build, continuous ready.
        ib.out_ready = 1'b1; rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_seq_word", ib.out_data, exp3[i]);
            chk("b_seq_valid", ib.out_valid, 1'b1);
        end
        // Default build, ready held low then raised.
        tick();
        rst_b = 1'b1; ib.out_ready = 1'b0;
        tick();
        rst_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b_hold_word", ib.out_data, 32'hDEAD_BEEF);
            chk("b_hold_valid", ib.out_valid, 1'b1);
            chk("b_hold_busy", ib.busy, 1'b0);
        end
        tick();
        ib.out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("b_after_ready", ib.out_data, 32'hBD5B_7DDE);

        // 4-bit build whose successor of SEED is always zero.
        tick();
        ic.out_ready = 1'b1; rst_c = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("c_word", ic.out_data, 4'h8);
            chk("c_valid", ic.out_valid, 1'b1);
            chk("c_lockup", ic.lockup, k > 0);
        end

        // STEPS=4 build: reset values, then 16 words at full rate with interval check.
        tick();
        @(negedge clk);
        chk("a_rst_word", ia.out_data, SEED_A);
        chk("a_rst_valid", ia.out_valid, 1'b1);
        chk("a_rst_flags", {ia.busy, ia.zero_seed, ia.lockup}, 3'b000);
        tick();
        rst_a = 1'b0;
        cur = SEED_A;
        gap_check = 1'b1;
        run_words(16, 100);
        gap_check = 1'b0;

        seed_end(2, 32'h1234_5678);
        seed_end(2, 32'h0);
        for (int it = 0; it < 12; it++) begin
            run_words(int'($urandom_range(1, 6)), 60);
            d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            seed_end(int'($urandom_range(0, 2)), d);
        end

        // Reset on the second FILL cycle.
        tick();
        ia.out_ready = 1'b0;
        repeat (5) tick();
        exp_q.push_back(cur);
        ia.out_ready = 1'b1; tick();
        ia.out_ready = 1'b0; tick();
        rst_a = 1'b1; tick();
        rst_a = 1'b0;
        @(negedge clk);
        chk("a_midfill_rst_word", ia.out_data, SEED_A);
        chk("a_midfill_rst_valid", ia.out_valid, 1'b1);
        chk("a_midfill_rst_busy", ia.busy, 1'b0);

        // Reset wins over a simultaneous reseed.
        tick();
        rst_a = 1'b1; ia.seed_load = 1'b1; ia.seed_data = 32'h1234_5678;
        tick();
        rst_a = 1'b0; ia.seed_load = 1'b0;
        @(negedge clk);
        chk("a_rst_vs_seed_word", ia.out_data, SEED_A);
        chk("a_rst_vs_seed_zs", ia.zero_seed, 1'b0);
        cur = SEED_A;
        run_words(4, 100);
        repeat (3) tick();
        chk("a_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
